// File: rtl/energy_fifo_tracker_pkg.sv
// Shared types and helpers for the energy FIFO tracker.
// Compare-mode encoding and the occupancy-width helper.
package energy_fifo_pkg;

  typedef enum logic [1:0] {
    CMP_OFF    = 2'd0,
    CMP_HEAD   = 2'd1,
    CMP_MIN    = 2'd2,
    CMP_MARGIN = 2'd3
  } cmp_mode_e;

  function automatic int usage_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/energy_fifo_tracker_if.sv
// Sample-in / spin-out handshake bundle of the energy FIFO tracker.
// The slave modport is the tracker's view; master is the surrounding logic.
interface energy_fifo_tracker_if #(
  parameter int NUM_SPIN         = 256,
  parameter int ENERGY_TOTAL_BIT = 32
);
  logic                               energy_valid_i;
  logic                               energy_ready_o;
  logic        [NUM_SPIN-1:0]         spin_i;
  logic signed [ENERGY_TOTAL_BIT-1:0] energy_i;
  logic                               spin_valid_o;
  logic                               spin_ready_i;
  logic        [NUM_SPIN-1:0]         spin_o;
  logic                               spin_push_none_o;

  modport master (
    output energy_valid_i, spin_i, energy_i, spin_ready_i,
    input  energy_ready_o, spin_valid_o, spin_o, spin_push_none_o
  );

  modport slave (
    input  energy_valid_i, spin_i, energy_i, spin_ready_i,
    output energy_ready_o, spin_valid_o, spin_o, spin_push_none_o
  );
endinterface

// File: rtl/energy_min_tree.sv
// Combinational signed minimum over DEPTH entries with a valid mask.
// Masked-off and padding leaves read as INIT_ENERGY so they never win.
module energy_min_tree
  import energy_fifo_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int ENERGY_TOTAL_BIT = 32,
  parameter logic signed [ENERGY_TOTAL_BIT-1:0] INIT_ENERGY =
    {1'b0, {(ENERGY_TOTAL_BIT-1){1'b1}}}
) (
  input  logic signed [ENERGY_TOTAL_BIT-1:0] data_i [DEPTH],
  input  logic        [DEPTH-1:0]            mask_i,
  output logic signed [ENERGY_TOTAL_BIT-1:0] min_o
);

  localparam int LEAVES = 1 << $clog2(DEPTH);

  logic signed [ENERGY_TOTAL_BIT-1:0] lvl [LEAVES];

  // NOTE: every variable in an always_comb gets a value on every path first; otherwise a latch is inferred.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) lvl[i] = INIT_ENERGY;
    for (int i = 0; i < DEPTH; i++) begin
      if (mask_i[i]) lvl[i] = data_i[i];
    end
    // Pairwise halving; node i only reads 2i and 2i+1, which are not yet overwritten.
    for (int s = LEAVES / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        lvl[i] = (lvl[2*i+1] < lvl[2*i]) ? lvl[2*i+1] : lvl[2*i];
      end
    end
    min_o = lvl[0];
  end

endmodule

// File: rtl/energy_fifo_tracker.sv
// Energy/spin FIFO maintainer: judges each sample against a selectable
// reference, keeps a circular energy FIFO and a 1-stage spin output.
module energy_fifo_tracker
  import energy_fifo_pkg::*;
#(
  parameter int NUM_SPIN         = 256,
  parameter int DEPTH            = 4,
  parameter int ENERGY_TOTAL_BIT = 32,
  parameter int CNT_W            = 16,
  parameter logic signed [ENERGY_TOTAL_BIT-1:0] INIT_ENERGY =
    {1'b0, {(ENERGY_TOTAL_BIT-1){1'b1}}},
  parameter int USAGE_W          = usage_width(DEPTH)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic                              flush_i,
  input  logic                              clr_stats_i,
  input  logic [1:0]                        cmp_mode_i,
  input  logic [ENERGY_TOTAL_BIT-1:0]       margin_i,
  energy_fifo_tracker_if.slave              io,
  output logic [USAGE_W-1:0]                usage_o,
  output logic [DEPTH*ENERGY_TOTAL_BIT-1:0] energy_mem_o,
  output logic [CNT_W-1:0]                  accept_cnt_o,
  output logic [CNT_W-1:0]                  reject_cnt_o
);

  localparam int EW    = ENERGY_TOTAL_BIT;
  localparam int CW    = EW + 2;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [EW-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [USAGE_W-1:0]     count;
  logic                   spin_valid_q, push_none_q;
  logic [NUM_SPIN-1:0]    spin_q;
  logic [CNT_W-1:0]       acc_q, rej_q;

  logic                   full, empty, ready, accept, out_hs, pop, reject;
  logic [DEPTH-1:0]       occ_mask;
  logic signed [EW-1:0]   min_e, ref_e, push_e;
  logic signed [CW-1:0]   energy_w, ref_w, sum_w;
  cmp_mode_e              mode;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign mode   = cmp_mode_e'(cmp_mode_i);
  assign full   = (count == USAGE_W'(DEPTH));
  assign empty  = (count == '0);
  assign out_hs = spin_valid_q & io.spin_ready_i;
  assign ready  = en_i & ~full & (~spin_valid_q | io.spin_ready_i);
  assign accept = io.energy_valid_i & ready;
  assign pop    = out_hs & ~empty;

  // Occupied slots are the `count` entries starting at rd_ptr, circularly.
  always_comb begin
    occ_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_mask[i] = ((i + DEPTH - int'(rd_ptr)) % DEPTH) < int'(count);
    end
  end

  energy_min_tree #(
    .DEPTH           (DEPTH),
    .ENERGY_TOTAL_BIT(EW),
    .INIT_ENERGY     (INIT_ENERGY)
  ) u_min_tree (
    .data_i(mem),
    .mask_i(occ_mask),
    .min_o (min_e)
  );

  // Two guard bits keep energy + margin exact for any operand values.
  always_comb begin
    ref_e    = empty ? INIT_ENERGY : ((mode == CMP_MIN) ? min_e : mem[rd_ptr]);
    energy_w = {{2{io.energy_i[EW-1]}}, io.energy_i};
    ref_w    = {{2{ref_e[EW-1]}}, ref_e};
    sum_w    = energy_w + {2'b00, margin_i};
    reject   = 1'b0;
    case (mode)
      CMP_HEAD, CMP_MIN: reject = (energy_w >= ref_w);
      CMP_MARGIN:        reject = (sum_w >= ref_w);
      default:           reject = 1'b0;
    endcase
    push_e = reject ? ref_e : io.energy_i;
  end

  // NOTE: storage has a defined reset/flush value, so it is a register file with reset rather than a RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_ENERGY;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_ENERGY;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_e;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + USAGE_W'(accept) - USAGE_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spin_valid_q <= 1'b0;
      push_none_q  <= 1'b0;
      spin_q       <= '0;
    end else if (flush_i) begin
      spin_valid_q <= 1'b0;
      push_none_q  <= 1'b0;
    end else if (accept) begin
      spin_valid_q <= 1'b1;
      push_none_q  <= reject;
      spin_q       <= io.spin_i;
    end else if (out_hs) begin
      spin_valid_q <= 1'b0;
    end
  end

  // A flushed sample is dropped, so it is not counted either.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      rej_q <= '0;
    end else if (clr_stats_i) begin
      acc_q <= '0;
      rej_q <= '0;
    end else if (accept && !flush_i) begin
      if (!reject && acc_q != '1) acc_q <= acc_q + 1'b1;
      if (reject && rej_q != '1)  rej_q <= rej_q + 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem_out
    assign energy_mem_o[g*EW +: EW] = mem[g];
  end

  assign io.energy_ready_o   = ready;
  assign io.spin_valid_o     = spin_valid_q;
  assign io.spin_o           = spin_q;
  assign io.spin_push_none_o = push_none_q;
  assign usage_o             = count;
  assign accept_cnt_o        = acc_q;
  assign reject_cnt_o        = rej_q;

endmodule

// File: tb/tb_energy_fifo_tracker.sv
// Directed, table-driven bench for energy_fifo_tracker (DEPTH=4, CNT_W=2).
// Each row is one clock: inputs, expected ready before the edge, expected state after it.
module tb_energy_fifo_tracker;
  import energy_fifo_pkg::*;

  localparam int NS    = 16;
  localparam int DEPTH = 4;
  localparam int EW    = 32;
  localparam int CNTW  = 2;
  localparam logic [EW-1:0] INIT = 32'h7fff_ffff;

  typedef struct {
    logic        en, flush, clr;
    logic [1:0]  mode;
    logic [31:0] margin;
    logic        valid;
    logic [15:0] spin;
    logic [31:0] energy;
    logic        srdy;
    logic        x_rdy, x_sv, x_pn;
    logic [15:0] x_spin;
    logic [2:0]  x_use;
    logic [1:0]  x_acc, x_rej;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en, flush, clr;
  logic [1:0]        mode;
  logic [EW-1:0]     margin;
  logic [2:0]        usage;
  logic [DEPTH*EW-1:0] mem_flat;
  logic [CNTW-1:0]   acc, rej;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  energy_fifo_tracker_if #(.NUM_SPIN(NS), .ENERGY_TOTAL_BIT(EW)) io ();

  energy_fifo_tracker #(
    .NUM_SPIN(NS), .DEPTH(DEPTH), .ENERGY_TOTAL_BIT(EW), .CNT_W(CNTW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .flush_i     (flush),
    .clr_stats_i (clr),
    .cmp_mode_i  (mode),
    .margin_i    (margin),
    .io          (io),
    .usage_o     (usage),
    .energy_mem_o(mem_flat),
    .accept_cnt_o(acc),
    .reject_cnt_o(rej)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t row(
    input logic en_v, fl_v, clr_v, input logic [1:0] md, input logic [31:0] mg,
    input logic v, input logic [15:0] sp, input logic [31:0] e, input logic sr,
    input logic xr, xsv, xpn, input logic [15:0] xs, input logic [2:0] xu,
    input logic [1:0] xa, xj);
    vec_t r;
    r.en = en_v; r.flush = fl_v; r.clr = clr_v; r.mode = md; r.margin = mg;
    r.valid = v; r.spin = sp; r.energy = e; r.srdy = sr;
    r.x_rdy = xr; r.x_sv = xsv; r.x_pn = xpn; r.x_spin = xs; r.x_use = xu;
    r.x_acc = xa; r.x_rej = xj;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    en                = v.en;
    flush             = v.flush;
    clr               = v.clr;
    mode              = v.mode;
    margin            = v.margin;
    io.energy_valid_i = v.valid;
    io.spin_i         = v.spin;
    io.energy_i       = v.energy;
    io.spin_ready_i   = v.srdy;
  endtask

  task automatic check_mem(input string tag, input logic [DEPTH*EW-1:0] exp);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s mem[%0d]", tag, i), mem_flat[i*EW +: EW], exp[i*EW +: EW]);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("r%0d ready", i + 1), io.energy_ready_o, vecs[i].x_rdy);
      @(posedge clk);
      #1;
      check($sformatf("r%0d spin_valid", i + 1), io.spin_valid_o, vecs[i].x_sv);
      check($sformatf("r%0d push_none", i + 1), io.spin_push_none_o, vecs[i].x_pn);
      check($sformatf("r%0d spin", i + 1), io.spin_o, vecs[i].x_spin);
      check($sformatf("r%0d usage", i + 1), usage, vecs[i].x_use);
      check($sformatf("r%0d accept_cnt", i + 1), acc, vecs[i].x_acc);
      check($sformatf("r%0d reject_cnt", i + 1), rej, vecs[i].x_rej);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark1, mark2;
    vec_t idle;

    // Head mode, ready downstream: 100 / 90 / 95 -> push_none 0,0,1
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0001,100,1, 1,1,0,16'h0001,1,1,0));
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0002, 90,1, 1,1,0,16'h0002,1,2,0));
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0003, 95,1, 1,1,1,16'h0003,1,2,1));
    mark1 = vecs.size();
    // Min mode: stalled stage blocks 60 until the drain cycle, where min is 40
    vecs.push_back(row(1,0,0,CMP_MIN,0,0,16'h0000,  0,1, 1,0,1,16'h0003,0,2,1));
    vecs.push_back(row(1,0,1,CMP_MIN,0,0,16'h0000,  0,0, 1,0,1,16'h0003,0,0,0));
    vecs.push_back(row(1,0,0,CMP_MIN,0,1,16'h0004, 50,0, 1,1,0,16'h0004,1,1,0));
    vecs.push_back(row(1,0,0,CMP_MIN,0,1,16'h0005, 40,1, 1,1,0,16'h0005,1,2,0));
    vecs.push_back(row(1,0,0,CMP_MIN,0,1,16'h0006, 60,0, 0,1,0,16'h0005,1,2,0));
    vecs.push_back(row(1,0,0,CMP_MIN,0,1,16'h0006, 60,1, 1,1,1,16'h0006,1,2,1));
    // Min mode must ignore stale (lower) unoccupied entries
    vecs.push_back(row(1,0,1,CMP_MIN,0,0,16'h0000,  0,1, 1,0,1,16'h0006,0,0,0));
    vecs.push_back(row(1,0,0,CMP_MIN,0,1,16'h0008, 95,1, 1,1,0,16'h0008,1,1,0));
    vecs.push_back(row(1,0,0,CMP_MIN,0,1,16'h0009, 92,1, 1,1,0,16'h0009,1,2,0));
    // Margin mode (10): 95 rejected vs 100, 89 accepted, 79+10==89 rejected
    vecs.push_back(row(1,0,1,CMP_MARGIN,10,0,16'h0000,  0,1, 1,0,0,16'h0009,0,0,0));
    vecs.push_back(row(1,0,0,CMP_MARGIN,10,1,16'h000a,100,1, 1,1,0,16'h000a,1,1,0));
    vecs.push_back(row(1,0,0,CMP_MARGIN,10,1,16'h000b, 95,1, 1,1,1,16'h000b,1,1,1));
    vecs.push_back(row(1,0,0,CMP_MARGIN,10,1,16'h000c, 89,1, 1,1,0,16'h000c,1,2,1));
    vecs.push_back(row(1,0,0,CMP_MARGIN,10,1,16'h000d, 79,1, 1,1,1,16'h000d,1,2,2));
    // Head mode equality rejects; reject count saturates at 3
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h000e, 89,1, 1,1,1,16'h000e,1,2,3));
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h000f,200,1, 1,1,1,16'h000f,1,2,3));
    // Off mode, downstream stuck: one sample held, ready low, then drained
    vecs.push_back(row(1,0,1,CMP_OFF,0,0,16'h0000,0,1, 1,0,1,16'h000f,0,0,0));
    vecs.push_back(row(1,0,0,CMP_OFF,0,1,16'h0a01,32'hffff_fffb,0, 1,1,0,16'h0a01,1,1,0));
    vecs.push_back(row(1,0,0,CMP_OFF,0,1,16'h0a02,32'hffff_fffa,0, 0,1,0,16'h0a01,1,1,0));
    vecs.push_back(row(1,0,0,CMP_OFF,0,1,16'h0a03,32'hffff_fff9,0, 0,1,0,16'h0a01,1,1,0));
    vecs.push_back(row(1,0,0,CMP_OFF,0,0,16'h0000,0,1, 1,0,0,16'h0a01,0,1,0));
    vecs.push_back(row(1,0,0,CMP_OFF,0,1,16'h0a04,INIT,1, 1,1,0,16'h0a04,1,2,0));
    // Disabled: no accept, but output stage still drains
    vecs.push_back(row(0,0,0,CMP_HEAD,0,1,16'h0a05,1,1, 0,0,0,16'h0a04,0,2,0));
    vecs.push_back(row(0,0,0,CMP_HEAD,0,1,16'h0a06,1,1, 0,0,0,16'h0a04,0,2,0));
    // Clear beats increment; flush drops sample + handshake; next compares to INIT
    vecs.push_back(row(1,0,1,CMP_HEAD,0,1,16'h0b01,70,1, 1,1,0,16'h0b01,1,0,0));
    vecs.push_back(row(1,1,0,CMP_HEAD,0,1,16'h0b02,60,1, 1,0,0,16'h0b01,0,0,0));
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0b03,32'h7fff_fffe,1, 1,1,0,16'h0b03,1,1,0));
    mark2 = vecs.size();
    // Five rejects saturate the 2-bit counter, then clear
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0c01,INIT,1, 1,1,1,16'h0c01,1,1,1));
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0c02,INIT,1, 1,1,1,16'h0c02,1,1,2));
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0c03,INIT,1, 1,1,1,16'h0c03,1,1,3));
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0c04,INIT,1, 1,1,1,16'h0c04,1,1,3));
    vecs.push_back(row(1,0,0,CMP_HEAD,0,1,16'h0c05,INIT,1, 1,1,1,16'h0c05,1,1,3));
    vecs.push_back(row(1,0,1,CMP_HEAD,0,0,16'h0000,0,1,    1,0,1,16'h0c05,0,0,0));

    idle = row(1,0,0,CMP_OFF,0,0,16'h0000,0,0, 0,0,0,16'h0000,0,0,0);
    drive(idle);
    rst_n = 1'b0;
    #12;
    check("reset spin_valid", io.spin_valid_o, 1'b0);
    check("reset push_none", io.spin_push_none_o, 1'b0);
    check("reset spin", io.spin_o, 16'h0);
    check("reset usage", usage, 3'd0);
    check("reset accept_cnt", acc, 2'd0);
    check("reset reject_cnt", rej, 2'd0);
    check("reset ready", io.energy_ready_o, 1'b1);
    check_mem("reset", {INIT, INIT, INIT, INIT});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_rows(0, mark1);
    check_mem("head", {INIT, 32'd90, 32'd90, 32'd100});
    run_rows(mark1, mark2);
    check_mem("flush", {INIT, INIT, INIT, 32'h7fff_fffe});
    run_rows(mark2, vecs.size());

    // Asynchronous reset between edges returns everything to reset values at once
    drive(row(1,0,0,CMP_HEAD,0,1,16'h0d01,5,0, 0,0,0,16'h0,0,0,0));
    @(posedge clk);
    #1;
    check("pre-reset spin_valid", io.spin_valid_o, 1'b1);
    check("pre-reset accept_cnt", acc, 2'd1);
    io.energy_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async spin_valid", io.spin_valid_o, 1'b0);
    check("async spin", io.spin_o, 16'h0);
    check("async usage", usage, 3'd0);
    check("async accept_cnt", acc, 2'd0);
    check_mem("async", {INIT, INIT, INIT, INIT});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset usage", usage, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
